// File: rtl/ex_mem_if.sv
// ex_mem_if: bundles the EX-side inputs and MEM-side outputs of the EX/MEM
// pipeline stage.
//   slave  modport: the stage itself (consumes ex_*, stall, flush; drives
//                   mem_*, flag_*, halted).
//   master modport: the upstream driver / hazard unit / MEM consumer view.
interface ex_mem_if;
    // EX side
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        stall;
    logic        flush;
    // MEM side
    logic        mem_valid;
    logic        mem_reg_we;
    logic        mem_mem_rd;
    logic        mem_mem_wr;
    logic [3:0]  mem_opcode;
    logic [3:0]  mem_rd;
    logic [15:0] mem_result;
    logic [15:0] mem_store_data;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        halted;

    modport slave (
        input  ex_valid, ex_opcode, ex_result, ex_ovfl, ex_store_data,
               ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, stall, flush,
        output mem_valid, mem_reg_we, mem_mem_rd, mem_mem_wr, mem_opcode,
               mem_rd, mem_result, mem_store_data, flag_z, flag_v, flag_n,
               halted
    );

    modport master (
        output ex_valid, ex_opcode, ex_result, ex_ovfl, ex_store_data,
               ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr, stall, flush,
        input  mem_valid, mem_reg_we, mem_mem_rd, mem_mem_wr, mem_opcode,
               mem_rd, mem_result, mem_store_data, flag_z, flag_v, flag_n,
               halted
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register. Latches the EX result and control
// bundle for MEM, owns the architectural Z/V/N flags, and captures HLT as a
// sticky halt.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : ex_mem_if.slave (ex_* / stall / flush in; mem_* / flags / halted out)
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    ex_mem_if.slave     bus
);
    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
        OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
        OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
        OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic {RUN, HALTED} state_t;

    state_t  state;
    opcode_t op;
    logic    upd_z;
    logic    upd_nv;

    assign op = opcode_t'(bus.ex_opcode);

    // Which flags the EX opcode is allowed to write.
    always_comb begin
        upd_z  = 1'b0;
        upd_nv = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                upd_z  = 1'b1;
                upd_nv = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_z = 1'b1;
            default: ;
        endcase
    end

    // NOTE: every register here, flags included, is reset; the block is small
    // and the flags are architectural, so no state may start as X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= RUN;
            bus.halted         <= 1'b0;
            bus.mem_valid      <= 1'b0;
            bus.mem_reg_we     <= 1'b0;
            bus.mem_mem_rd     <= 1'b0;
            bus.mem_mem_wr     <= 1'b0;
            bus.mem_opcode     <= 4'h0;
            bus.mem_rd         <= 4'h0;
            bus.mem_result     <= 16'h0000;
            bus.mem_store_data <= 16'h0000;
            bus.flag_z         <= 1'b0;
            bus.flag_v         <= 1'b0;
            bus.flag_n         <= 1'b0;
        end else if (state == RUN && !bus.stall) begin
            // NOTE: non-blocking assignments throughout so every register
            // samples pre-edge values regardless of statement order.
            if (bus.flush) begin
                bus.mem_valid      <= 1'b0;
                bus.mem_reg_we     <= 1'b0;
                bus.mem_mem_rd     <= 1'b0;
                bus.mem_mem_wr     <= 1'b0;
                bus.mem_opcode     <= 4'h0;
                bus.mem_rd         <= 4'h0;
                bus.mem_result     <= 16'h0000;
                bus.mem_store_data <= 16'h0000;
            end else begin
                // Side-effecting controls are gated so a bubble never writes.
                bus.mem_valid      <= bus.ex_valid;
                bus.mem_reg_we     <= bus.ex_reg_we & bus.ex_valid;
                bus.mem_mem_rd     <= bus.ex_mem_rd & bus.ex_valid;
                bus.mem_mem_wr     <= bus.ex_mem_wr & bus.ex_valid;
                bus.mem_opcode     <= bus.ex_opcode;
                bus.mem_rd         <= bus.ex_rd;
                bus.mem_result     <= bus.ex_result;
                bus.mem_store_data <= bus.ex_store_data;
                if (bus.ex_valid) begin
                    // Z reflects the saturated ALU output as delivered.
                    if (upd_z)
                        bus.flag_z <= (bus.ex_result == 16'h0000);
                    if (upd_nv) begin
                        bus.flag_n <= bus.ex_result[15];
                        bus.flag_v <= bus.ex_ovfl;
                    end
                    if (op == OP_HLT) begin
                        state      <= HALTED;
                        bus.halted <= 1'b1;
                    end
                end
            end
        end
        // stall=1 or HALTED: everything holds.
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed-vector self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ex_mem_if bus ();

    ex_mem_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic [15:0] sd, input logic [3:0] rd,
                         input logic we, input logic mrd, input logic mwr,
                         input logic st, input logic fl);
        bus.ex_valid      = v;
        bus.ex_opcode     = op;
        bus.ex_result     = res;
        bus.ex_ovfl       = ov;
        bus.ex_store_data = sd;
        bus.ex_rd         = rd;
        bus.ex_reg_we     = we;
        bus.ex_mem_rd     = mrd;
        bus.ex_mem_wr     = mwr;
        bus.stall         = st;
        bus.flush         = fl;
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n, input logic v);
        check({tag, ".z"}, {15'd0, bus.flag_z}, {15'd0, z});
        check({tag, ".n"}, {15'd0, bus.flag_n}, {15'd0, n});
        check({tag, ".v"}, {15'd0, bus.flag_v}, {15'd0, v});
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".valid"},  {15'd0, bus.mem_valid},  16'd0);
        check({tag, ".we"},     {15'd0, bus.mem_reg_we}, 16'd0);
        check({tag, ".mrd"},    {15'd0, bus.mem_mem_rd}, 16'd0);
        check({tag, ".mwr"},    {15'd0, bus.mem_mem_wr}, 16'd0);
        check({tag, ".op"},     {12'd0, bus.mem_opcode}, 16'd0);
        check({tag, ".rd"},     {12'd0, bus.mem_rd},     16'd0);
        check({tag, ".res"},    bus.mem_result,          16'd0);
        check({tag, ".sd"},     bus.mem_store_data,      16'd0);
        check({tag, ".halted"}, {15'd0, bus.halted},     16'd0);
        check_flags(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;

        // Get some non-zero state in flight, then reset mid-stream.
        drive(1, 4'h1, 16'h8000, 1, 16'h1111, 4'h5, 1, 0, 0, 0, 0);
        step();
        check("pre_rst.n", {15'd0, bus.flag_n}, 16'd1);
        rst_n = 1'b0;
        #1;
        check_reset("rst1");
        #2 rst_n = 1'b1;

        // ADD, result 0 -> Z=1, N=0, V=0
        drive(1, 4'h0, 16'h0000, 0, 16'h0, 4'd3, 1, 0, 0, 0, 0);
        step();
        check("add.res",   bus.mem_result,          16'h0000);
        check("add.rd",    {12'd0, bus.mem_rd},     16'd3);
        check("add.we",    {15'd0, bus.mem_reg_we}, 16'd1);
        check("add.valid", {15'd0, bus.mem_valid},  16'd1);
        check_flags("add", 1, 0, 0);

        // Flag masking
        drive(1, 4'h1, 16'h8000, 1, 16'h0, 4'd4, 1, 0, 0, 0, 0);
        step();
        check_flags("sub", 0, 1, 1);
        drive(1, 4'h3, 16'h0000, 0, 16'h0, 4'd4, 1, 0, 0, 0, 0);
        step();
        check("red.op", {12'd0, bus.mem_opcode}, 16'd3);
        check_flags("red", 0, 1, 1);
        drive(1, 4'h2, 16'h0000, 0, 16'h0, 4'd4, 1, 0, 0, 0, 0);
        step();
        check_flags("xor", 1, 1, 1);

        // Stall: ADD 5 latched, then SUB 0 held off for 3 cycles
        drive(1, 4'h0, 16'h0005, 0, 16'h0, 4'd2, 1, 0, 0, 0, 0);
        step();
        check("add5.res", bus.mem_result, 16'h0005);
        check_flags("add5", 0, 0, 0);
        drive(1, 4'h1, 16'h0000, 0, 16'h0, 4'd6, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.res", bus.mem_result,          16'h0005);
            check("stall.op",  {12'd0, bus.mem_opcode}, 16'h0000);
            check("stall.rd",  {12'd0, bus.mem_rd},     16'd2);
            check_flags("stall", 0, 0, 0);
        end
        bus.stall = 1'b0;
        step();
        check("unstall.op", {12'd0, bus.mem_opcode}, 16'h0001);
        check("unstall.rd", {12'd0, bus.mem_rd},     16'd6);
        check_flags("unstall", 1, 0, 0);

        // Flush of a valid SW
        drive(1, 4'h9, 16'h0100, 0, 16'hABCD, 4'd1, 0, 0, 1, 0, 1);
        step();
        check("flush.valid", {15'd0, bus.mem_valid},  16'd0);
        check("flush.mwr",   {15'd0, bus.mem_mem_wr}, 16'd0);
        check("flush.sd",    bus.mem_store_data,      16'h0000);
        check_flags("flush", 1, 0, 0);

        // LW latched, then stall+flush together must hold it
        drive(1, 4'h8, 16'h0020, 0, 16'h0, 4'd7, 1, 1, 0, 0, 0);
        step();
        check("lw.mrd", {15'd0, bus.mem_mem_rd}, 16'd1);
        drive(1, 4'h0, 16'h8000, 1, 16'h0, 4'd9, 1, 0, 0, 1, 1);
        step();
        check("sf.valid", {15'd0, bus.mem_valid},  16'd1);
        check("sf.mrd",   {15'd0, bus.mem_mem_rd}, 16'd1);
        check("sf.we",    {15'd0, bus.mem_reg_we}, 16'd1);
        check("sf.res",   bus.mem_result,          16'h0020);
        check("sf.rd",    {12'd0, bus.mem_rd},     16'd7);
        check("sf.op",    {12'd0, bus.mem_opcode}, 16'h0008);
        check_flags("sf", 1, 0, 0);

        // Invalid EX slot with reg_we asserted
        drive(0, 4'h0, 16'h8000, 1, 16'h0, 4'd5, 1, 1, 1, 0, 0);
        step();
        check("inv.valid", {15'd0, bus.mem_valid},  16'd0);
        check("inv.we",    {15'd0, bus.mem_reg_we}, 16'd0);
        check("inv.mrd",   {15'd0, bus.mem_mem_rd}, 16'd0);
        check("inv.mwr",   {15'd0, bus.mem_mem_wr}, 16'd0);
        check_flags("inv", 1, 0, 0);

        // Halt
        drive(1, 4'hF, 16'h0000, 0, 16'h0, 4'd0, 0, 0, 0, 0, 0);
        step();
        check("hlt.halted", {15'd0, bus.halted},     16'd1);
        check("hlt.valid",  {15'd0, bus.mem_valid},  16'd1);
        check("hlt.op",     {12'd0, bus.mem_opcode}, 16'h000F);
        drive(1, 4'h0, 16'h0000, 1, 16'h0, 4'd2, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("halt.halted", {15'd0, bus.halted},     16'd1);
            check("halt.op",     {12'd0, bus.mem_opcode}, 16'h000F);
            check("halt.we",     {15'd0, bus.mem_reg_we}, 16'd0);
            check("halt.rd",     {12'd0, bus.mem_rd},     16'd0);
            check("halt.valid",  {15'd0, bus.mem_valid},  16'd1);
            check_flags("halt", 1, 0, 0);
        end

        // Reset clears halt; the first edge afterwards advances normally
        rst_n = 1'b0;
        #1;
        check_reset("rst2");
        #2 rst_n = 1'b1;
        drive(1, 4'h0, 16'h0009, 0, 16'h0, 4'd8, 1, 0, 0, 0, 0);
        step();
        check("post.res",    bus.mem_result,      16'h0009);
        check("post.halted", {15'd0, bus.halted}, 16'd0);
        check_flags("post", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
